// File: rtl/pipeline_stall_controller_if.sv
// ============================================================================
// Module   : pipeline_stall_controller_if
// Brief    : Hazard inputs and stall/flush control outputs of the ID-stage
//            stall sequencer, bundled with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipeline_stall_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) ();

  logic                  in_ifid_valid;
  logic                  in_use_rs1;
  logic                  in_use_rs2;
  logic [REG_ADDR_W-1:0] in_rs1_ifid;
  logic [REG_ADDR_W-1:0] in_rs2_ifid;
  logic                  in_memread_idex;
  logic [REG_ADDR_W-1:0] in_rd_idex;
  logic                  in_redirect;
  logic                  in_imem_busy;
  logic                  in_dmem_busy;
  logic                  in_cnt_clear;

  logic                  out_pc_write;
  logic                  out_ifid_write;
  logic                  out_ifid_flush;
  logic                  out_idex_bubble;
  logic                  out_pipe_hold;
  logic [1:0]            out_state;
  logic [CNT_W-1:0]      out_stall_cnt;

  modport master (
    output in_ifid_valid, in_use_rs1, in_use_rs2, in_rs1_ifid, in_rs2_ifid,
           in_memread_idex, in_rd_idex, in_redirect, in_imem_busy,
           in_dmem_busy, in_cnt_clear,
    input  out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble,
           out_pipe_hold, out_state, out_stall_cnt
  );

  modport slave (
    input  in_ifid_valid, in_use_rs1, in_use_rs2, in_rs1_ifid, in_rs2_ifid,
           in_memread_idex, in_rd_idex, in_redirect, in_imem_busy,
           in_dmem_busy, in_cnt_clear,
    output out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble,
           out_pipe_hold, out_state, out_stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// Module   : pipeline_stall_controller
// Brief    : ID-stage stall/flush sequencer arbitrating dmem wait, redirect,
//            load-use and imem wait, with a saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  pipeline_stall_controller_if.slave   bus
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_W-1:0]  c_FL_LOAD  = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FL_W-1:0]  r_fcnt;
  logic [FL_W-1:0]  w_fcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu_hit;
  logic w_run_like;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_pipe_hold;

  assign w_lu_hit = bus.in_memread_idex && bus.in_ifid_valid &&
                    (bus.in_rd_idex != {REG_ADDR_W{1'b0}}) &&
                    ((bus.in_use_rs1 && (bus.in_rs1_ifid == bus.in_rd_idex)) ||
                     (bus.in_use_rs2 && (bus.in_rs2_ifid == bus.in_rd_idex)));

  // MEM_WAIT with dmem released behaves exactly like RUN in the same cycle.
  assign w_run_like = (r_state == S_RUN) || (r_state == S_MEM_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_hold   = 1'b0;
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;

    if (!reset_n) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_pipe_hold  = 1'b1;
      w_state_nxt  = S_RUN;
      w_fcnt_nxt   = '0;
    end else if (bus.in_dmem_busy) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_pipe_hold  = 1'b1;
      w_state_nxt  = S_MEM_WAIT;
    end else if (bus.in_redirect) begin
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_fcnt_nxt    = c_FL_LOAD;
      w_state_nxt   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
    end else if (w_lu_hit && w_run_like) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_state_nxt   = S_LU_STALL;
    end else if (bus.in_imem_busy) begin
      // Fetch stall freezes the sequencer, including any flush countdown.
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b1;
      w_state_nxt  = w_run_like ? S_RUN : r_state;
    end else if (r_state == S_FLUSH) begin
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b1;
      if (r_fcnt <= FL_W'(1)) begin
        w_fcnt_nxt  = '0;
        w_state_nxt = S_RUN;
      end else begin
        w_fcnt_nxt  = r_fcnt - FL_W'(1);
      end
    end else begin
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (bus.in_cnt_clear) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.out_pc_write    = w_pc_write;
  assign bus.out_ifid_write  = w_ifid_write;
  assign bus.out_ifid_flush  = w_ifid_flush;
  assign bus.out_idex_bubble = w_idex_bubble;
  assign bus.out_pipe_hold   = w_pipe_hold;
  assign bus.out_state       = r_state;
  assign bus.out_stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// ============================================================================
// Module   : tb_pipeline_stall_controller
// Brief    : Two controller instances (default and FLUSH_CYCLES=3/CNT_W=2)
//            driven identically and compared with a rule-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_controller;

  logic clk;
  logic s_rst_n;
  logic s_valid, s_u1, s_u2, s_memrd, s_redir, s_imem, s_dmem, s_clr;
  logic [4:0] s_rs1, s_rs2, s_rd;

  int n_cmp;
  int n_err;

  pipeline_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) if_a ();
  pipeline_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(2))  if_b ();

  pipeline_stall_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .reset_n(s_rst_n), .bus(if_a.slave));
  pipeline_stall_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset_n(s_rst_n), .bus(if_b.slave));

  assign if_a.in_ifid_valid = s_valid;   assign if_b.in_ifid_valid = s_valid;
  assign if_a.in_use_rs1 = s_u1;         assign if_b.in_use_rs1 = s_u1;
  assign if_a.in_use_rs2 = s_u2;         assign if_b.in_use_rs2 = s_u2;
  assign if_a.in_rs1_ifid = s_rs1;       assign if_b.in_rs1_ifid = s_rs1;
  assign if_a.in_rs2_ifid = s_rs2;       assign if_b.in_rs2_ifid = s_rs2;
  assign if_a.in_memread_idex = s_memrd; assign if_b.in_memread_idex = s_memrd;
  assign if_a.in_rd_idex = s_rd;         assign if_b.in_rd_idex = s_rd;
  assign if_a.in_redirect = s_redir;     assign if_b.in_redirect = s_redir;
  assign if_a.in_imem_busy = s_imem;     assign if_b.in_imem_busy = s_imem;
  assign if_a.in_dmem_busy = s_dmem;     assign if_b.in_dmem_busy = s_dmem;
  assign if_a.in_cnt_clear = s_clr;      assign if_b.in_cnt_clear = s_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=RUN 1=LU_STALL 2=MEM_WAIT 3=FLUSH, per instance.
  int              m_mode [2];
  int              m_left [2];
  longint unsigned m_cnt  [2];
  int              m_fc   [2] = '{1, 3};
  longint unsigned m_cmax [2] = '{64'hFFFF_FFFF, 64'd3};
  int              n_mode [2];
  int              n_left [2];
  longint unsigned n_cnt  [2];
  logic e_pc [2], e_ifw [2], e_fl [2], e_bub [2], e_hold [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval(input int i);
    bit lu, stall_rules_as_run;
    if (!s_rst_n) begin
      m_mode[i] = 0; m_left[i] = 0; m_cnt[i] = 0;
      e_pc[i] = 0; e_ifw[i] = 0; e_fl[i] = 0; e_bub[i] = 0; e_hold[i] = 1;
      n_mode[i] = 0; n_left[i] = 0; n_cnt[i] = 0;
      return;
    end
    lu = s_memrd && s_valid && (s_rd != 0) &&
         ((s_u1 && s_rs1 == s_rd) || (s_u2 && s_rs2 == s_rd));
    stall_rules_as_run = (m_mode[i] == 0) || (m_mode[i] == 2);
    e_pc[i] = 1; e_ifw[i] = 0; e_fl[i] = 0; e_bub[i] = 0; e_hold[i] = 0;
    n_mode[i] = m_mode[i]; n_left[i] = m_left[i];
    if (s_dmem) begin
      e_pc[i] = 0; e_hold[i] = 1; n_mode[i] = 2;
    end else if (s_redir) begin
      e_fl[i] = 1; e_bub[i] = 1;
      n_left[i] = m_fc[i] - 1;
      n_mode[i] = (m_fc[i] > 1) ? 3 : 0;
    end else if (lu && stall_rules_as_run) begin
      e_pc[i] = 0; e_bub[i] = 1; n_mode[i] = 1;
    end else if (s_imem) begin
      e_pc[i] = 0; e_fl[i] = 1;
      if (stall_rules_as_run) n_mode[i] = 0;
    end else if (m_mode[i] == 3) begin
      e_fl[i] = 1;
      n_left[i] = m_left[i] - 1;
      if (n_left[i] <= 0) begin n_mode[i] = 0; n_left[i] = 0; end
    end else begin
      e_ifw[i] = 1; n_mode[i] = 0;
    end
    if (s_clr) n_cnt[i] = 0;
    else if (!e_pc[i] && m_cnt[i] < m_cmax[i]) n_cnt[i] = m_cnt[i] + 1;
    else n_cnt[i] = m_cnt[i];
  endtask

  task automatic check_inst(input int i, input string nm, input logic pc, input logic ifw,
                            input logic fl, input logic bub, input logic hold,
                            input logic [1:0] st, input logic [63:0] cnt);
    chk({nm, ".pc_write"},    {63'd0, pc},   {63'd0, e_pc[i]});
    chk({nm, ".ifid_write"},  {63'd0, ifw},  {63'd0, e_ifw[i]});
    chk({nm, ".ifid_flush"},  {63'd0, fl},   {63'd0, e_fl[i]});
    chk({nm, ".idex_bubble"}, {63'd0, bub},  {63'd0, e_bub[i]});
    chk({nm, ".pipe_hold"},   {63'd0, hold}, {63'd0, e_hold[i]});
    chk({nm, ".state"},       {62'd0, st},   64'(m_mode[i]));
    chk({nm, ".stall_cnt"},   cnt,           m_cnt[i]);
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then advance model.
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_eval(i);
    check_inst(0, "A", if_a.out_pc_write, if_a.out_ifid_write, if_a.out_ifid_flush,
               if_a.out_idex_bubble, if_a.out_pipe_hold, if_a.out_state,
               64'(if_a.out_stall_cnt));
    check_inst(1, "B", if_b.out_pc_write, if_b.out_ifid_write, if_b.out_ifid_flush,
               if_b.out_idex_bubble, if_b.out_pipe_hold, if_b.out_state,
               64'(if_b.out_stall_cnt));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = n_mode[i]; m_left[i] = n_left[i]; m_cnt[i] = n_cnt[i];
    end
    #1;
  endtask

  task automatic idle();
    s_valid = 1; s_u1 = 0; s_u2 = 0; s_memrd = 0; s_redir = 0;
    s_imem = 0; s_dmem = 0; s_clr = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    s_memrd = 1; s_rd = rd; s_rs1 = rd; s_u1 = 1; s_valid = 1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 2; i++) begin m_mode[i] = 0; m_left[i] = 0; m_cnt[i] = 0; end
    idle();
    s_rst_n = 0;
    repeat (2) cyc();
    s_rst_n = 1;

    repeat (10) cyc();
    chk("idle.cnt_a", 64'(if_a.out_stall_cnt), 64'd0);
    chk("idle.state_a", 64'(if_a.out_state), 64'd0);

    set_lu(5'd5); cyc();
    idle(); repeat (2) cyc();
    chk("lu.cnt_a", 64'(if_a.out_stall_cnt), 64'd1);
    set_lu(5'd0); cyc();
    idle(); cyc();
    chk("lu_rd0.cnt_a", 64'(if_a.out_stall_cnt), 64'd1);

    set_lu(5'd5); s_redir = 1; s_dmem = 1;
    repeat (4) cyc();
    chk("memwait.state_a", 64'(if_a.out_state), 64'd2);
    s_dmem = 0; cyc();
    idle(); repeat (3) cyc();
    chk("memwait.cnt_a", 64'(if_a.out_stall_cnt), 64'd5);
    chk("sat.cnt_b", 64'(if_b.out_stall_cnt), 64'd3);
    s_clr = 1; cyc(); s_clr = 0;
    chk("clear.cnt_a", 64'(if_a.out_stall_cnt), 64'd0);
    chk("clear.cnt_b", 64'(if_b.out_stall_cnt), 64'd0);

    s_redir = 1; cyc(); s_redir = 0;
    chk("flush.state_b", 64'(if_b.out_state), 64'd3);
    repeat (4) cyc();
    s_redir = 1; cyc(); s_redir = 0; cyc();
    s_redir = 1; cyc(); s_redir = 0; repeat (4) cyc();

    s_imem = 1; repeat (3) cyc();
    chk("imem.cnt_a", 64'(if_a.out_stall_cnt), 64'd3);
    s_redir = 1; cyc();
    idle(); repeat (3) cyc();
    chk("imem_redir.cnt_a", 64'(if_a.out_stall_cnt), 64'd3);

    s_dmem = 1; repeat (2) cyc();
    s_rst_n = 0; #1;
    chk("rst_async.state_a", 64'(if_a.out_state), 64'd0);
    chk("rst_async.hold_a", 64'(if_a.out_pipe_hold), 64'd1);
    chk("rst_async.pc_a", 64'(if_a.out_pc_write), 64'd0);
    cyc();
    s_rst_n = 1; idle(); cyc();

    for (int n = 0; n < 3000; n++) begin
      s_valid = ($urandom_range(0, 9) != 0);
      s_u1    = $urandom_range(0, 1);
      s_u2    = $urandom_range(0, 1);
      s_rs1   = 5'($urandom_range(0, 5));
      s_rs2   = 5'($urandom_range(0, 5));
      s_rd    = 5'($urandom_range(0, 5));
      s_memrd = ($urandom_range(0, 9) < 4);
      s_redir = ($urandom_range(0, 9) == 0);
      s_imem  = ($urandom_range(0, 99) < 15);
      s_dmem  = ($urandom_range(0, 99) < 12);
      s_clr   = ($urandom_range(0, 99) < 3);
      s_rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
